// File: rtl/xheep_led_status_ctrl_pkg.sv
// Shared types and timing constants for the LED status controller and its exit-code blinker.
package led_status_pkg;

    typedef enum logic [2:0] {
        LED_OFF       = 3'd0,
        LED_ON        = 3'd1,
        LED_HEARTBEAT = 3'd2,
        LED_PWM       = 3'd3,
        LED_CODE      = 3'd4
    } led_mode_e;

    typedef enum logic [1:0] {
        BLINK_IDLE,
        BLINK_MARK,
        BLINK_SPACE,
        BLINK_PAUSE
    } blink_state_e;

    localparam int unsigned UNITS_W = 4;

    localparam logic [UNITS_W-1:0] MARK1_UNITS = 4'd3;
    localparam logic [UNITS_W-1:0] MARK0_UNITS = 4'd1;
    localparam logic [UNITS_W-1:0] SPACE_UNITS = 4'd1;
    localparam logic [UNITS_W-1:0] PAUSE_UNITS = 4'd8;

    // Length of a blinker state in time units; IDLE has no length.
    function automatic logic [UNITS_W-1:0] state_units(input blink_state_e st, input logic code_bit);
        logic [UNITS_W-1:0] units;
        case (st)
            BLINK_MARK:  units = code_bit ? MARK1_UNITS : MARK0_UNITS;
            BLINK_SPACE: units = SPACE_UNITS;
            BLINK_PAUSE: units = PAUSE_UNITS;
            default:     units = '0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/xheep_led_status_ctrl_blinker.sv
// Exit-code blinker: latches the exit value on a valid rising edge and sends it MSB first
// as long (1) / short (0) marks separated by spaces, with a pause between repetitions.
module led_code_blinker
    import led_status_pkg::*;
#(
    parameter int unsigned CODE_WIDTH = 8,
    parameter int unsigned UNIT_LOG2  = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [CODE_WIDTH-1:0] value_i,
    input  logic                  clear_i,
    output logic                  blink_o,
    output logic                  busy_o,
    output logic [CODE_WIDTH-1:0] value_o
);

    localparam int unsigned IDX_W = (CODE_WIDTH > 1) ? $clog2(CODE_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_WIDTH - 1);

    blink_state_e          state_q, state_d;
    logic [UNIT_LOG2-1:0]  unit_cnt_q, unit_cnt_d;
    logic [UNITS_W-1:0]    units_q, units_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;
    logic                  valid_q;
    logic                  blink_q, blink_d;
    logic                  busy_q, busy_d;
    logic                  rise;
    logic                  unit_tick;
    logic                  last_unit;

    always_comb begin
        rise       = valid_i & ~valid_q;
        unit_tick  = &unit_cnt_q;
        last_unit  = unit_tick &&
                     (units_q == state_units(state_q, code_q[bit_idx_q]) - UNITS_W'(1));

        state_d    = state_q;
        unit_cnt_d = unit_cnt_q + UNIT_LOG2'(1);
        units_d    = unit_tick ? units_q + UNITS_W'(1) : units_q;
        bit_idx_d  = bit_idx_q;
        code_d     = code_q;

        case (state_q)
            BLINK_IDLE: begin
                // Unit counter is held at 0 here so timing starts fresh on leaving IDLE.
                unit_cnt_d = '0;
                units_d    = '0;
                if (rise) begin
                    code_d    = value_i;
                    bit_idx_d = LAST_IDX;
                    state_d   = BLINK_MARK;
                end
            end
            BLINK_MARK: begin
                if (last_unit) begin
                    units_d = '0;
                    state_d = BLINK_SPACE;
                end
            end
            BLINK_SPACE: begin
                if (last_unit) begin
                    units_d = '0;
                    if (bit_idx_q == '0) begin
                        state_d = BLINK_PAUSE;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        state_d   = BLINK_MARK;
                    end
                end
            end
            default: begin
                if (last_unit) begin
                    units_d   = '0;
                    bit_idx_d = LAST_IDX;
                    state_d   = BLINK_MARK;
                end
            end
        endcase

        if (clear_i) begin
            state_d    = BLINK_IDLE;
            code_d     = '0;
            units_d    = '0;
            unit_cnt_d = '0;
        end

        blink_d = (state_d == BLINK_MARK);
        busy_d  = (state_d != BLINK_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BLINK_IDLE;
            unit_cnt_q <= '0;
            units_q    <= '0;
            bit_idx_q  <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            blink_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            units_q    <= units_d;
            bit_idx_q  <= bit_idx_d;
            code_q     <= code_d;
            valid_q    <= valid_i;
            blink_q    <= blink_d;
            busy_q     <= busy_d;
        end
    end

    assign blink_o = blink_q;
    assign busy_o  = busy_q;
    assign value_o = code_q;

endmodule

// File: rtl/xheep_led_status_ctrl.sv
// Board status LED controller: per-channel off/on/heartbeat/PWM/exit-code modes, registered LED drive.
module xheep_led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 4,
    parameter int unsigned CNT_WIDTH  = 27,
    parameter int unsigned PWM_WIDTH  = 8,
    parameter int unsigned CODE_WIDTH = 8,
    parameter int unsigned UNIT_LOG2  = 22
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [3*NUM_LEDS-1:0]         mode_i,
    input  logic [PWM_WIDTH*NUM_LEDS-1:0] duty_i,
    input  logic                          exit_valid_i,
    input  logic [31:0]                   exit_value_i,
    input  logic                          clear_i,
    output logic [NUM_LEDS-1:0]           led_o,
    output logic                          code_busy_o,
    output logic [CODE_WIDTH-1:0]         code_value_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_LEDS-1:0]  led_q, led_d;
    logic                 blink;
    logic                 unused_exit_bits;

    assign unused_exit_bits = ^exit_value_i[31:CODE_WIDTH];

    // Channels decode the counter value being registered this cycle, so the
    // heartbeat first goes high exactly 2**(CNT_WIDTH-1) cycles after reset.
    assign cnt_d = cnt_q + CNT_WIDTH'(1);

    for (genvar k = 0; k < NUM_LEDS; k++) begin : g_chan
        led_mode_e ch_mode;
        logic      ch_led;

        assign ch_mode = led_mode_e'(mode_i[3*k +: 3]);

        always_comb begin
            ch_led = 1'b0;
            case (ch_mode)
                LED_OFF:       ch_led = 1'b0;
                LED_ON:        ch_led = 1'b1;
                LED_HEARTBEAT: ch_led = cnt_d[CNT_WIDTH-1];
                LED_PWM:       ch_led = (cnt_d[PWM_WIDTH-1:0] < duty_i[PWM_WIDTH*k +: PWM_WIDTH]);
                LED_CODE:      ch_led = blink;
                default:       ch_led = 1'b0;
            endcase
        end

        assign led_d[k] = ch_led;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            led_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            led_q <= led_d;
        end
    end

    led_code_blinker #(
        .CODE_WIDTH (CODE_WIDTH),
        .UNIT_LOG2  (UNIT_LOG2)
    ) u_blinker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (exit_valid_i),
        .value_i (exit_value_i[CODE_WIDTH-1:0]),
        .clear_i (clear_i),
        .blink_o (blink),
        .busy_o  (code_busy_o),
        .value_o (code_value_o)
    );

    assign led_o = led_q;

endmodule

// File: tb/tb_xheep_led_status_ctrl.sv
// Scoreboard bench for xheep_led_status_ctrl with small timing parameters.
module tb_xheep_led_status_ctrl;

    localparam int unsigned NUM_LEDS   = 4;
    localparam int unsigned CNT_WIDTH  = 6;
    localparam int unsigned PWM_WIDTH  = 4;
    localparam int unsigned CODE_WIDTH = 4;
    localparam int unsigned UNIT_LOG2  = 2;
    localparam int unsigned UNIT       = 1 << UNIT_LOG2;

    logic                          clk = 1'b0;
    logic                          rst_i;
    logic [3*NUM_LEDS-1:0]         mode_i;
    logic [PWM_WIDTH*NUM_LEDS-1:0] duty_i;
    logic                          exit_valid_i;
    logic [31:0]                   exit_value_i;
    logic                          clear_i;
    logic [NUM_LEDS-1:0]           led_o;
    logic                          code_busy_o;
    logic [CODE_WIDTH-1:0]         code_value_o;

    always #5 clk = ~clk;

    xheep_led_status_ctrl #(
        .NUM_LEDS   (NUM_LEDS),
        .CNT_WIDTH  (CNT_WIDTH),
        .PWM_WIDTH  (PWM_WIDTH),
        .CODE_WIDTH (CODE_WIDTH),
        .UNIT_LOG2  (UNIT_LOG2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .mode_i       (mode_i),
        .duty_i       (duty_i),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .clear_i      (clear_i),
        .led_o        (led_o),
        .code_busy_o  (code_busy_o),
        .code_value_o (code_value_o)
    );

    typedef struct packed {
        logic [NUM_LEDS-1:0]   led;
        logic                  busy;
        logic [CODE_WIDTH-1:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned           m_cnt;
    int                    m_phase;
    logic [CODE_WIDTH-1:0] m_code;
    logic                  m_vprev;
    logic                  m_blink;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned mark_len(input logic b);
        return b ? 3 * UNIT : UNIT;
    endfunction

    function automatic int unsigned period_of(input logic [CODE_WIDTH-1:0] code);
        int unsigned p;
        p = 8 * UNIT;
        for (int b = 0; b < CODE_WIDTH; b++) p += mark_len(code[b]) + UNIT;
        return p;
    endfunction

    // Expected blinker level j cycles after the latch: marks/spaces MSB first, then pause.
    function automatic logic pat_at(input logic [CODE_WIDTH-1:0] code, input int unsigned j);
        int unsigned t;
        t = 0;
        for (int b = CODE_WIDTH - 1; b >= 0; b--) begin
            if (j < t + mark_len(code[b])) return 1'b1;
            t += mark_len(code[b]);
            if (j < t + UNIT) return 1'b0;
            t += UNIT;
        end
        return 1'b0;
    endfunction

    function automatic logic chan_model(input int k);
        logic [2:0]           md;
        logic [PWM_WIDTH-1:0] dt;
        logic [CNT_WIDTH-1:0] c;
        md = mode_i[3*k +: 3];
        dt = duty_i[PWM_WIDTH*k +: PWM_WIDTH];
        c  = CNT_WIDTH'(m_cnt);
        case (md)
            3'd1:    return 1'b1;
            3'd2:    return c[CNT_WIDTH-1];
            3'd3:    return (c[PWM_WIDTH-1:0] < dt);
            3'd4:    return m_blink;
            default: return 1'b0;
        endcase
    endfunction

    // Predict the outputs after the coming edge, push them, then compare after the edge.
    task automatic step();
        exp_t e;
        exp_t o;
        e = '0;
        if (rst_i) begin
            m_cnt   = 0;
            m_phase = -1;
            m_code  = '0;
            m_vprev = 1'b0;
            m_blink = 1'b0;
        end else begin
            m_cnt = (m_cnt + 1) % (1 << CNT_WIDTH);
            for (int k = 0; k < NUM_LEDS; k++) e.led[k] = chan_model(k);
            if (clear_i) begin
                m_phase = -1;
                m_code  = '0;
            end else if (m_phase < 0) begin
                if (exit_valid_i && !m_vprev) begin
                    m_phase = 0;
                    m_code  = exit_value_i[CODE_WIDTH-1:0];
                end
            end else begin
                m_phase = (m_phase + 1) % period_of(m_code);
            end
            m_blink = (m_phase >= 0) ? pat_at(m_code, m_phase) : 1'b0;
            m_vprev = exit_valid_i;
            e.busy  = (m_phase >= 0);
            e.val   = m_code;
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        o = sb_q.pop_front();
        check("led_o", 32'(led_o), 32'(o.led));
        check("code_busy_o", 32'(code_busy_o), 32'(o.busy));
        check("code_value_o", 32'(code_value_o), 32'(o.val));
    endtask

    initial begin
        int unsigned hi;
        logic [PWM_WIDTH-1:0] duties [3];
        duties[0] = 4'd0;
        duties[1] = 4'd5;
        duties[2] = 4'd15;

        rst_i        = 1'b1;
        mode_i       = '0;
        duty_i       = '0;
        exit_valid_i = 1'b0;
        exit_value_i = '0;
        clear_i      = 1'b0;
        @(negedge clk);

        // Reset and all-OFF, then ON on channel 1.
        repeat (3) step();
        rst_i = 1'b0;
        repeat (5) step();
        mode_i[5:3] = 3'd1;
        step();
        check("on_ch1", 32'(led_o), 32'h2);
        repeat (3) step();

        // Heartbeat on channel 0 from a fresh reset.
        rst_i       = 1'b1;
        mode_i[2:0] = 3'd2;
        step();
        rst_i = 1'b0;
        repeat (31) step();
        check("hb_low_31", 32'(led_o[0]), 32'h0);
        step();
        check("hb_high_32", 32'(led_o[0]), 32'h1);
        repeat (40) step();

        // PWM on channel 3: count high cycles over a full 16-cycle window.
        mode_i[11:9] = 3'd3;
        for (int i = 0; i < 3; i++) begin
            duty_i[15:12] = duties[i];
            step();
            hi = 0;
            repeat (16) begin
                step();
                hi += 32'(led_o[3]);
            end
            check("pwm_on_cycles", hi, 32'(duties[i]));
        end

        // Exit code 0xA on channel 2.
        mode_i[8:6]  = 3'd4;
        exit_value_i = 32'h1234_567A;
        exit_valid_i = 1'b1;
        step();
        hi = 0;
        repeat (80) begin
            step();
            hi += 32'(led_o[2]);
        end
        check("code_a_on_cycles", hi, 32'd32);
        repeat (20) step();

        // New edge while busy must be ignored.
        exit_valid_i = 1'b0;
        exit_value_i = 32'h3;
        step();
        exit_valid_i = 1'b1;
        step();
        repeat (60) step();
        check("busy_keeps_code", 32'(code_value_o), 32'hA);

        // Clear with a coincident rising edge, then a held-high level.
        exit_valid_i = 1'b0;
        step();
        exit_valid_i = 1'b1;
        clear_i      = 1'b1;
        step();
        clear_i = 1'b0;
        repeat (20) step();
        check("no_relatch_level", 32'(code_busy_o), 32'h0);

        // Relatch 0x5, reset inside the first mark, level-high at release relatches.
        exit_valid_i = 1'b0;
        exit_value_i = 32'h5;
        step();
        exit_valid_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b1;
        step();
        check("rst_mid_mark", {30'd0, code_busy_o, led_o[2]}, 32'h0);
        rst_i = 1'b0;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
